// File: rtl/booth_pkg.sv
// Shared package for the Booth multiplier / divider arithmetic library.
// Holds the sequencer state encoding, the default operand width and a
// two's-complement absolute-value helper.
package booth_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_e;

    // Absolute value of a sign-extended operand. Callers truncate the result
    // to their own width; the magnitude of MIN lands exactly in WIDTH bits.
    function automatic logic [63:0] abs_val(input logic [63:0] v);
        return v[63] ? (~v + 64'd1) : v;
    endfunction

endpackage

// File: rtl/booth_div_step.sv
// One restoring-division iteration: shift in the next dividend bit,
// trial-subtract the divisor magnitude, keep or restore, emit a quotient bit.
module booth_div_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH:0]   prem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] dmag_i,
    output logic [WIDTH:0]   prem_o,
    output logic             qbit_o
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;

    // Trial subtraction; a clear sign bit means the divisor fits.
    always_comb begin
        // NOTE: every combinational output is given a value on every path so no latch is inferred.
        shifted = {prem_i, bit_i};
        diff    = shifted - {2'b00, dmag_i};
        qbit_o  = ~diff[WIDTH+1];
        prem_o  = diff[WIDTH+1] ? shifted[WIDTH:0] : diff[WIDTH:0];
    end

endmodule

// File: rtl/booth_divider.sv
// Sequential signed divider: restoring division on magnitudes, one quotient
// bit per clock, then a sign-correction cycle. Shares the start/done
// handshake of the Booth multiplier.
// Optional feature: define BOOTH_DIV_OVF_EN to add the overflow port and
// saturate MIN / -1 to MAX instead of wrapping.
module booth_divider
    import booth_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
`ifdef BOOTH_DIV_OVF_EN
    output logic             overflow,
`endif
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] dividend_q;
    logic [WIDTH-1:0] a_mag_q;
    logic [WIDTH-1:0] b_mag_q;
    logic [WIDTH:0]   prem_q;
    logic [WIDTH-1:0] quot_q;
    logic             q_neg_q;
    logic             r_neg_q;
    logic             div0_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             div_by_zero_q;
`ifdef BOOTH_DIV_OVF_EN
    logic             ovf_case_q;
    logic             overflow_q;
`endif

    logic [WIDTH:0]   prem_d;
    logic             qbit_d;

    booth_div_step #(.WIDTH(WIDTH)) u_step (
        .prem_i (prem_q),
        .bit_i  (a_mag_q[WIDTH-1]),
        .dmag_i (b_mag_q),
        .prem_o (prem_d),
        .qbit_o (qbit_d)
    );

    // Sequencer and datapath: capture in IDLE, iterate in RUN, sign-correct in FIX.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            dividend_q    <= '0;
            a_mag_q       <= '0;
            b_mag_q       <= '0;
            prem_q        <= '0;
            quot_q        <= '0;
            q_neg_q       <= 1'b0;
            r_neg_q       <= 1'b0;
            div0_q        <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
`ifdef BOOTH_DIV_OVF_EN
            ovf_case_q    <= 1'b0;
            overflow_q    <= 1'b0;
`endif
        end else begin
            // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        dividend_q    <= dividend;
                        a_mag_q       <= WIDTH'(abs_val(64'($signed(dividend))));
                        b_mag_q       <= WIDTH'(abs_val(64'($signed(divisor))));
                        prem_q        <= '0;
                        quot_q        <= '0;
                        q_neg_q       <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        r_neg_q       <= dividend[WIDTH-1];
                        div0_q        <= (divisor == '0);
                        busy_q        <= 1'b1;
                        div_by_zero_q <= 1'b0;
                        cnt_q         <= CW'(WIDTH - 1);
`ifdef BOOTH_DIV_OVF_EN
                        ovf_case_q    <= (dividend == {1'b1, {(WIDTH-1){1'b0}}}) &&
                                         (divisor == '1);
                        overflow_q    <= 1'b0;
`endif
                        state_q       <= (divisor == '0) ? FIX : RUN;
                    end
                end
                RUN: begin
                    prem_q  <= prem_d;
                    quot_q  <= {quot_q[WIDTH-2:0], qbit_d};
                    a_mag_q <= a_mag_q << 1;
                    cnt_q   <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    if (div0_q) begin
                        quotient_q    <= '1;
                        remainder_q   <= dividend_q;
                        div_by_zero_q <= 1'b1;
                    end else begin
                        quotient_q  <= q_neg_q ? -quot_q : quot_q;
                        remainder_q <= r_neg_q ? -prem_q[WIDTH-1:0] : prem_q[WIDTH-1:0];
`ifdef BOOTH_DIV_OVF_EN
                        if (ovf_case_q) begin
                            quotient_q  <= {1'b0, {(WIDTH-1){1'b1}}};
                            remainder_q <= '0;
                            overflow_q  <= 1'b1;
                        end
`endif
                    end
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = div_by_zero_q;
`ifdef BOOTH_DIV_OVF_EN
    assign overflow    = overflow_q;
`endif

endmodule

// File: tb/tb_booth_divider.sv
// Directed self-checking bench for booth_divider at WIDTH=4.
// Define BOOTH_DIV_OVF_EN on both bench and RTL to exercise saturation.
module tb_booth_divider;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
`ifdef BOOTH_DIV_OVF_EN
    logic         overflow;
`endif

    int total;
    int passed;
    int edges;
    int busy_cyc;
    logic done_seen;

    booth_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
`ifdef BOOTH_DIV_OVF_EN
        .overflow    (overflow),
`endif
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Counts edges (the accepting edge is edge 1) until done, sampling 1 time unit after each edge.
    task automatic wait_done(output int n_edges, output int n_busy);
        n_edges   = 0;
        n_busy    = 0;
        done_seen = 1'b0;
        while (n_edges < 20 && !done_seen) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            n_edges++;
            if (done) done_seen = 1'b1;
            else if (busy) n_busy++;
        end
        check("done_seen", {31'd0, done_seen}, 32'd1);
    endtask

    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        wait_done(edges, busy_cyc);
    endtask

    initial begin
        total    = 0;
        passed   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #12;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_quot", {28'd0, quotient}, 32'd0);
        check("rst_rem",  {28'd0, remainder}, 32'd0);
        check("rst_dbz",  {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // 7 / 2
        run_div(4'd7, 4'd2);
        check("7/2_edges", edges, 32'd6);
        check("7/2_busy_cycles", busy_cyc, 32'd5);
        check("7/2_busy_at_done", {31'd0, busy}, 32'd0);
        check("7/2_quot", {28'd0, quotient}, 32'h3);
        check("7/2_rem",  {28'd0, remainder}, 32'h1);
        @(posedge clk); #1;
        check("done_one_cycle", {31'd0, done}, 32'd0);
        check("quot_holds", {28'd0, quotient}, 32'h3);

        // Sign combinations
        run_div(4'h9, 4'd2);
        check("-7/2_quot", {28'd0, quotient}, 32'hD);
        check("-7/2_rem",  {28'd0, remainder}, 32'hF);
        run_div(4'd7, 4'hE);
        check("7/-2_quot", {28'd0, quotient}, 32'hD);
        check("7/-2_rem",  {28'd0, remainder}, 32'h1);
        run_div(4'h8, 4'h8);
        check("-8/-8_quot", {28'd0, quotient}, 32'h1);
        check("-8/-8_rem",  {28'd0, remainder}, 32'h0);

        // MIN / -1
        run_div(4'h8, 4'hF);
`ifdef BOOTH_DIV_OVF_EN
        check("ovf_quot", {28'd0, quotient}, 32'h7);
        check("ovf_rem",  {28'd0, remainder}, 32'h0);
        check("ovf_flag", {31'd0, overflow}, 32'd1);
`else
        check("wrap_quot", {28'd0, quotient}, 32'h8);
        check("wrap_rem",  {28'd0, remainder}, 32'h0);
`endif

        // Divide by zero, then a normal division clears the flag
        run_div(4'd5, 4'd0);
        check("dbz_edges", edges, 32'd2);
        check("dbz_flag", {31'd0, div_by_zero}, 32'd1);
        check("dbz_quot", {28'd0, quotient}, 32'hF);
        check("dbz_rem",  {28'd0, remainder}, 32'h5);
        run_div(4'd6, 4'd3);
        check("6/3_dbz_clear", {31'd0, div_by_zero}, 32'd0);
        check("6/3_quot", {28'd0, quotient}, 32'h2);
        check("6/3_rem",  {28'd0, remainder}, 32'h0);
`ifdef BOOTH_DIV_OVF_EN
        check("ovf_clear", {31'd0, overflow}, 32'd0);
`endif

        // Start pulsed mid-RUN is ignored
        @(negedge clk);
        start    = 1'b1;
        dividend = 4'd7;
        divisor  = 4'd2;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        start    = 1'b1;
        dividend = 4'd1;
        divisor  = 4'd1;
        wait_done(edges, busy_cyc);
        check("midrun_edges", edges, 32'd4);
        check("midrun_quot", {28'd0, quotient}, 32'h3);
        check("midrun_rem",  {28'd0, remainder}, 32'h1);

        // Start held on the done cycle launches a back-to-back division
        start    = 1'b1;
        dividend = 4'd6;
        divisor  = 4'd3;
        wait_done(edges, busy_cyc);
        check("b2b_edges", edges, 32'd6);
        check("b2b_quot", {28'd0, quotient}, 32'h2);
        check("b2b_rem",  {28'd0, remainder}, 32'h0);

        // Reset during RUN clears everything before the next edge
        @(negedge clk);
        start    = 1'b1;
        dividend = 4'd7;
        divisor  = 4'd2;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        check("mid_rst_quot", {28'd0, quotient}, 32'd0);
        check("mid_rst_rem",  {28'd0, remainder}, 32'd0);
        check("mid_rst_dbz",  {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_div(4'd3, 4'd3);
        check("3/3_edges", edges, 32'd6);
        check("3/3_quot", {28'd0, quotient}, 32'h1);
        check("3/3_rem",  {28'd0, remainder}, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/booth_divider.md
Name: booth_divider

Overview:
- Sequential signed divider: the inverse of the Booth multiplier datapath in the same arithmetic library.
- Computes quotient and remainder of two WIDTH-bit two's-complement operands using iterative restoring division on magnitudes, one bit per clock, followed by a sign-correction cycle.
- Sits beside the multiplier under a shared start/done handshake so the same controller can issue either operation.

Parameters:
- WIDTH, 4, operand, quotient and remainder width in bits; must be >= 2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request to begin a division; sampled only in IDLE.
- dividend  input  WIDTH  signed dividend; captured on the accepted start edge.
- divisor  input  WIDTH  signed divisor; captured on the accepted start edge.
- busy  output  1  high from the edge after start is accepted until the edge on which done rises.
- done  output  1  one-cycle pulse; results are valid from this cycle onward.
- quotient  output  WIDTH  signed quotient; holds until the next accepted start.
- remainder  output  WIDTH  signed remainder; holds until the next accepted start.
- div_by_zero  output  1  set with done when divisor was 0; cleared on the next accepted start.
- overflow  output  1  present only when BOOTH_DIV_OVF_EN is defined (see Optional Feature).

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-operation):
  - State goes to IDLE.
  - busy, done, quotient, remainder, div_by_zero and overflow all go to 0.
  - Any in-flight division is discarded.
- Arithmetic:
  - Truncating division toward zero.
  - Remainder sign follows the dividend; |remainder| < |divisor|.
  - dividend = quotient*divisor + remainder, evaluated modulo 2^WIDTH.
- Internal datapath:
  - Magnitudes are held as WIDTH-bit unsigned values, so |MIN| = 2^(WIDTH-1) fits.
  - Partial remainder register is WIDTH+1 bits.
  - Signs of quotient and remainder are latched at start.
- States:
  - IDLE:
    - start=1: capture operands, clear done, div_by_zero and overflow, set busy.
    - Next state is FIX if divisor==0, otherwise RUN with iteration counter = WIDTH-1.
    - start=0: stay in IDLE.
  - RUN:
    - Each cycle, shift the partial remainder left by one and bring in the next dividend magnitude bit (MSB first).
    - Trial-subtract the divisor magnitude. If the result is non-negative, keep it and shift in a quotient bit of 1; otherwise restore and shift in 0.
    - Counter decrements each cycle; after the iteration at counter 0, go to FIX.
    - RUN therefore lasts exactly WIDTH cycles.
  - FIX:
    - Apply sign correction: quotient is negated if the operand signs differ; remainder is negated if the dividend is negative.
    - Load the quotient and remainder outputs.
    - Assert done for one cycle, deassert busy, then return to IDLE.
- Latency:
  - done is high for exactly one cycle, WIDTH+2 rising edges after the edge that accepted start.
  - When the divisor is 0, done rises 2 edges after the accepting edge.
- Back-to-back operation: start is accepted in the same cycle done is high, because the state is already IDLE then.
- start while busy: ignored; operands on the inputs are not sampled.
- Divide by zero: quotient = all ones, remainder = dividend, div_by_zero = 1.
- Overflow case (dividend = MIN, divisor = -1), without the macro: quotient = MIN (wraps), remainder = 0.
- Divisor = MIN: handled correctly, e.g. MIN/MIN gives quotient 1, remainder 0.

Optional Feature:
- Macro: BOOTH_DIV_OVF_EN.
- Defined:
  - overflow port exists.
  - For MIN / -1, quotient saturates to MAX (0111..1), remainder = 0, and overflow = 1 with done.
  - overflow clears on the next accepted start or on reset.
- Undefined: no overflow port; the result wraps to MIN as described above.

Decomposition:
- Shared package booth_pkg holds:
  - the state enum (IDLE, RUN, FIX);
  - the default width constant;
  - a helper function for two's-complement absolute value.
  The multiplier reuses the same package.
- One natural sub-module, booth_div_step: a combinational single restoring iteration.
  - Inputs: partial remainder, next dividend bit, divisor magnitude.
  - Outputs: new partial remainder and quotient bit.

Test Plan (WIDTH=4):
- 7 / 2 -> quotient 4'h3, remainder 4'h1; done exactly 6 edges after start; busy high for the 5 cycles before done.
- -7 / 2 and 7 / -2 -> quotient 4'hD (-3) in both cases; remainders 4'hF (-1) and 4'h1 respectively; -8 / -8 -> quotient 1, remainder 0.
- -8 / -1:
  - macro off -> quotient 4'h8, remainder 0;
  - macro on -> quotient 4'h7, remainder 0, overflow 1.
- 5 / 0 -> done 2 edges after start, div_by_zero 1, quotient 4'hF, remainder 4'h5; next start with 6 / 3 clears div_by_zero and gives quotient 2, remainder 0.
- start pulsed again mid-RUN with different operands -> ignored, original result unchanged. start held high on the done cycle -> second division begins and completes 6 edges later.
- rst asserted during RUN -> busy, done and all outputs are 0 before the next clock edge; after release, a fresh 3 / 3 -> quotient 1, remainder 0.
